// File: rtl/pipe_robot_pkg.sv
// Shared types, grid and VGA timing constants, colours and the initial world map
// for the pipe-cleaning robot.
package pipe_robot_pkg;

    localparam int unsigned GRID_ROWS  = 15;
    localparam int unsigned GRID_COLS  = 20;
    localparam int unsigned GRID_CELLS = GRID_ROWS * GRID_COLS;
    localparam int unsigned ROW_W      = 4;
    localparam int unsigned COL_W      = 5;
    localparam int unsigned CELL_IDX_W = 9;
    localparam int unsigned MAP_W      = 2 * GRID_CELLS;

    localparam int unsigned CNT_W        = 10;
    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 751;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 491;
    localparam int unsigned V_TOTAL      = 525;

    localparam int unsigned COLOR_W = 8;

    typedef enum logic [3:0] {
        ORI_N = 4'b0000,
        ORI_S = 4'b0001,
        ORI_E = 4'b0010,
        ORI_W = 4'b0011
    } ori_e;

    typedef enum logic [2:0] {
        ST_SEARCH  = 3'b000,
        ST_ROTATE  = 3'b001,
        ST_REMOVE  = 3'b010,
        ST_STANDBY = 3'b011,
        ST_FIRST   = 3'b100,
        ST_RESET   = 3'b101
    } state_e;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_WALL  = 2'b01,
        CELL_TRASH = 2'b10
    } cell_e;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } pos_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    localparam rgb_t COL_ROBOT = '{8'hFF, 8'h00, 8'h00};
    localparam rgb_t COL_WALL  = '{8'h80, 8'h80, 8'h80};
    localparam rgb_t COL_TRASH = '{8'h00, 8'hFF, 8'h00};
    localparam rgb_t COL_EMPTY = '{8'h00, 8'h00, 8'h00};
    localparam rgb_t COL_GRID  = '{8'h40, 8'h40, 8'h40};

    function automatic cell_e init_cell(input int unsigned r, input int unsigned c);
        if (r == 0 || r == GRID_ROWS - 1 || c == 0 || c == GRID_COLS - 1) return CELL_WALL;
        if (c == 10 && r >= 3 && r <= 11) return CELL_WALL;
        if ((r == 1 && c == 5) || (r == 7 && c == 12) || (r == 13 && c == 18)) return CELL_TRASH;
        return CELL_EMPTY;
    endfunction

    function automatic logic [MAP_W-1:0] init_map();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int unsigned r = 0; r < GRID_ROWS; r++) begin
            for (int unsigned c = 0; c < GRID_COLS; c++) begin
                m[2*(r*GRID_COLS+c) +: 2] = init_cell(r, c);
            end
        end
        return m;
    endfunction

    localparam logic [MAP_W-1:0] INIT_MAP = init_map();

    function automatic logic [CELL_IDX_W-1:0] cell_idx(input pos_t p);
        return CELL_IDX_W'(p.row) * CELL_IDX_W'(GRID_COLS) + CELL_IDX_W'(p.col);
    endfunction

    function automatic logic [1:0] cell_of(input logic [MAP_W-1:0] m,
                                           input logic [CELL_IDX_W-1:0] idx);
        return m[{idx, 1'b0} +: 2];
    endfunction

    function automatic ori_e rot_right(input ori_e o);
        case (o)
            ORI_N:   return ORI_E;
            ORI_E:   return ORI_S;
            ORI_S:   return ORI_W;
            default: return ORI_N;
        endcase
    endfunction

    function automatic ori_e rot_left(input ori_e o);
        case (o)
            ORI_N:   return ORI_W;
            ORI_W:   return ORI_S;
            ORI_S:   return ORI_E;
            default: return ORI_N;
        endcase
    endfunction

    // North decreases the row index.
    function automatic pos_t step_pos(input pos_t p, input ori_e o);
        pos_t n;
        n = p;
        case (o)
            ORI_N:   n.row = p.row - ROW_W'(1);
            ORI_S:   n.row = p.row + ROW_W'(1);
            ORI_E:   n.col = p.col + COL_W'(1);
            ORI_W:   n.col = p.col - COL_W'(1);
            default: n = p;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_robot_top_vga_timing.sv
// 640x480@60 raster counters with registered active-low syncs; counters advance on pix_en_i.
module vga_timing
    import pipe_robot_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pix_en_i,
    output logic [CNT_W-1:0] pixel_x_o,
    output logic [CNT_W-1:0] pixel_y_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             active_c_o
);

    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             hs_q, vs_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en_i) begin
            if (x_q == CNT_W'(H_TOTAL - 1)) begin
                x_d = '0;
                y_d = (y_q == CNT_W'(V_TOTAL - 1)) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end
    end

    // Syncs are registered from the same counter value the pixel colour uses, keeping them aligned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q  <= '0;
            y_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            hs_q <= !((x_q >= CNT_W'(H_SYNC_START)) && (x_q <= CNT_W'(H_SYNC_END)));
            vs_q <= !((y_q >= CNT_W'(V_SYNC_START)) && (y_q <= CNT_W'(V_SYNC_END)));
        end
    end

    assign pixel_x_o  = x_q;
    assign pixel_y_o  = y_q;
    assign hs_o       = hs_q;
    assign vs_o       = vs_q;
    assign active_c_o = (x_q < CNT_W'(H_ACTIVE)) && (y_q < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/pipe_robot_top.sv
// Pipe-cleaning robot top: tile world, left-wall-following FSM, joypad moves and VGA renderer.
// Define ROBOT_GRID_OVERLAY_EN to draw tile grid lines.
module pipe_robot_top
    import pipe_robot_pkg::*;
#(
    parameter int unsigned START_ROW = 1,
    parameter int unsigned START_COL = 1,
    parameter int unsigned TILE_LOG2 = 5
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    input  logic        Pino1,
    input  logic        Pino2,
    input  logic        Pino3,
    input  logic        Pino4,
    input  logic        Pino6,
    input  logic        Pino9,
    output logic        Select,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_CLK,
    output logic [8:0]  LEDG
);

    localparam pos_t START_POS = '{ROW_W'(START_ROW), COL_W'(START_COL)};

    logic [1:0] key_sync_q, sw_sync_q;
    logic       key_prev_q, sw_prev_q;
    logic [3:0] joy_s1_q, joy_s2_q;
    logic       step_c, sw_fall_c;
    logic [3:0] joy_c;

    logic             pix_q;
    logic [CNT_W-1:0] pixel_x, pixel_y;
    logic             hs, vs, active_c;

    logic [MAP_W-1:0] map_q;
    state_e           state_q, state_d;
    pos_t             pos_q, pos_d;
    ori_e             ori_q, ori_d;
    logic             mode_q;

    pos_t ahead_c, left_c, man_tgt_c, tile_c;
    ori_e man_ori_c;
    logic head_c, left_wall_c, barrier_c, under_c, man_any_c, man_blocked_c;
    logic clr_under_c, clr_ahead_c, grid_line_c;
    logic [1:0] tile_cell_c;
    rgb_t rgb_q, rgb_d;

    logic unused_inputs;
    assign unused_inputs = ^{KEY[2:0], SW[17:1], Pino6, Pino9};

    // Sync chains reset low so a button must be seen released before a press registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_sync_q <= '0;
            key_prev_q <= 1'b0;
            sw_sync_q  <= '0;
            sw_prev_q  <= 1'b0;
            joy_s1_q   <= '1;
            joy_s2_q   <= '1;
            pix_q      <= 1'b0;
        end else begin
            key_sync_q <= {key_sync_q[0], KEY[3]};
            key_prev_q <= key_sync_q[1];
            sw_sync_q  <= {sw_sync_q[0], SW[0]};
            sw_prev_q  <= sw_sync_q[1];
            joy_s1_q   <= {Pino1, Pino2, Pino3, Pino4};
            joy_s2_q   <= joy_s1_q;
            pix_q      <= ~pix_q;
        end
    end

    assign step_c    = key_prev_q & ~key_sync_q[1];
    assign sw_fall_c = sw_prev_q & ~sw_sync_q[1];
    assign joy_c     = ~joy_s2_q;

    vga_timing u_vga (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .pix_en_i   (pix_q),
        .pixel_x_o  (pixel_x),
        .pixel_y_o  (pixel_y),
        .hs_o       (hs),
        .vs_o       (vs),
        .active_c_o (active_c)
    );

    assign ahead_c     = step_pos(pos_q, ori_q);
    assign left_c      = step_pos(pos_q, rot_left(ori_q));
    assign head_c      = cell_of(map_q, cell_idx(ahead_c)) == CELL_WALL;
    assign left_wall_c = cell_of(map_q, cell_idx(left_c)) == CELL_WALL;
    assign barrier_c   = cell_of(map_q, cell_idx(ahead_c)) == CELL_TRASH;
    assign under_c     = cell_of(map_q, cell_idx(pos_q)) == CELL_TRASH;

    always_comb begin
        man_ori_c = ORI_E;
        if (joy_c[3])      man_ori_c = ORI_N;
        else if (joy_c[2]) man_ori_c = ORI_S;
        else if (joy_c[1]) man_ori_c = ORI_W;
    end

    assign man_any_c     = |joy_c;
    assign man_tgt_c     = step_pos(pos_q, man_ori_c);
    assign man_blocked_c = cell_of(map_q, cell_idx(man_tgt_c)) == CELL_WALL;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        ori_d       = ori_q;
        clr_under_c = 1'b0;
        clr_ahead_c = 1'b0;
        if (step_c) begin
            clr_under_c = under_c;
            if (!mode_q) begin
                state_d = ST_STANDBY;
                if (man_any_c) begin
                    ori_d = man_ori_c;
                    if (!man_blocked_c) pos_d = man_tgt_c;
                end
            end else begin
                case (state_q)
                    ST_RESET: begin
                        pos_d   = START_POS;
                        ori_d   = ORI_N;
                        state_d = ST_FIRST;
                    end
                    ST_STANDBY: state_d = ST_FIRST;
                    ST_FIRST, ST_ROTATE: begin
                        if (!head_c) begin
                            pos_d   = ahead_c;
                            state_d = ST_SEARCH;
                        end else begin
                            ori_d   = rot_right(ori_q);
                            state_d = ST_ROTATE;
                        end
                    end
                    ST_SEARCH: begin
                        if (barrier_c) begin
                            state_d = ST_REMOVE;
                        end else if (!left_wall_c) begin
                            ori_d   = rot_left(ori_q);
                            state_d = ST_REMOVE;
                        end else if (!head_c) begin
                            pos_d   = ahead_c;
                        end else begin
                            ori_d   = rot_right(ori_q);
                            state_d = ST_ROTATE;
                        end
                    end
                    ST_REMOVE: begin
                        if (barrier_c) begin
                            clr_ahead_c = 1'b1;
                            state_d     = ST_SEARCH;
                        end else if (!head_c) begin
                            pos_d   = ahead_c;
                            state_d = ST_SEARCH;
                        end else begin
                            ori_d   = rot_right(ori_q);
                            state_d = ST_ROTATE;
                        end
                    end
                    default: state_d = ST_RESET;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            pos_q   <= START_POS;
            ori_q   <= ORI_N;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            ori_q   <= ori_d;
            mode_q  <= mode_q ^ sw_fall_c;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            map_q <= INIT_MAP;
        end else begin
            if (clr_under_c) map_q[{cell_idx(pos_q), 1'b0} +: 2] <= CELL_EMPTY;
            if (clr_ahead_c) map_q[{cell_idx(ahead_c), 1'b0} +: 2] <= CELL_EMPTY;
        end
    end

    assign tile_c      = '{ROW_W'(pixel_y >> TILE_LOG2), COL_W'(pixel_x >> TILE_LOG2)};
    assign tile_cell_c = active_c ? cell_of(map_q, cell_idx(tile_c)) : CELL_EMPTY;

`ifdef ROBOT_GRID_OVERLAY_EN
    assign grid_line_c = (pixel_x[TILE_LOG2-1:0] == '0) || (pixel_y[TILE_LOG2-1:0] == '0);
`else
    logic unused_grid;
    assign unused_grid = ^{pixel_x[TILE_LOG2-1:0], pixel_y[TILE_LOG2-1:0]};
    assign grid_line_c = 1'b0;
`endif

    always_comb begin
        rgb_d = COL_EMPTY;
        if (active_c) begin
            if (tile_c == pos_q) begin
                rgb_d = COL_ROBOT;
            end else if (grid_line_c) begin
                rgb_d = COL_GRID;
            end else begin
                case (tile_cell_c)
                    CELL_WALL:  rgb_d = COL_WALL;
                    CELL_TRASH: rgb_d = COL_TRASH;
                    default:    rgb_d = COL_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) rgb_q <= COL_EMPTY;
        else       rgb_q <= rgb_d;
    end

    assign VGA_R   = rgb_q.r;
    assign VGA_G   = rgb_q.g;
    assign VGA_B   = rgb_q.b;
    assign VGA_HS  = hs;
    assign VGA_VS  = vs;
    assign VGA_CLK = pix_q;
    assign Select  = 1'b1;
    assign LEDG    = {1'b0, ori_q, mode_q, state_q};

endmodule

// File: tb/tb_pipe_robot_top.sv
// Directed bench for pipe_robot_top: reset, sync timing, auto wall-following, trash removal,
// async reset and manual joypad moves.
module tb_pipe_robot_top;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic        Pino1, Pino2, Pino3, Pino4, Pino6, Pino9;
    logic        Select;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_CLK;
    logic [8:0]  LEDG;

    int passed = 0;
    int total  = 0;

    pipe_robot_top dut (
        .CLOCK_50 (CLOCK_50), .reset (reset), .KEY (KEY), .SW (SW),
        .Pino1 (Pino1), .Pino2 (Pino2), .Pino3 (Pino3), .Pino4 (Pino4),
        .Pino6 (Pino6), .Pino9 (Pino9), .Select (Select),
        .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B),
        .VGA_HS (VGA_HS), .VGA_VS (VGA_VS), .VGA_CLK (VGA_CLK), .LEDG (LEDG)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(3); reset = 1'b0; tick(5);
    endtask

    task automatic press_step();
        KEY[3] = 1'b0; tick(4); KEY[3] = 1'b1; tick(4);
    endtask

    task automatic toggle_mode();
        SW[0] = 1'b1; tick(4); SW[0] = 1'b0; tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(2);
        total++; if (LEDG !== 9'b0_0000_0_101) $display("FAIL reset_ledg: got %b expected %b", LEDG, 9'b0_0000_0_101); else passed++;
        total++; if ({VGA_HS, VGA_VS} !== 2'b11) $display("FAIL reset_sync: got %b expected 11", {VGA_HS, VGA_VS}); else passed++;
        total++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) $display("FAIL reset_rgb: got %h expected 000000", {VGA_R, VGA_G, VGA_B}); else passed++;
        total++; if ({dut.pos_q.row, dut.pos_q.col} !== {4'd1, 5'd1}) $display("FAIL reset_pose: got r%0d c%0d expected r1 c1", dut.pos_q.row, dut.pos_q.col); else passed++;
        total++; if (Select !== 1'b1) $display("FAIL select: got %b expected 1", Select); else passed++;
        reset = 1'b0; tick(4);
        total++; if ({VGA_R, VGA_G, VGA_B} !== 24'h808080) $display("FAIL pixel00_wall: got %h expected 808080", {VGA_R, VGA_G, VGA_B}); else passed++;
        tick(5);
    endtask

    task automatic test_sync_timing();
        int hs_low = 0;
        int vs_low = 0;
        int lit    = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge VGA_CLK); #1;
            if (!VGA_HS) hs_low++;
            if (!VGA_VS) vs_low++;
            if (VGA_R != 8'h00) lit++;
        end
        total++; if (hs_low !== 96) $display("FAIL hs_low_width: got %0d expected 96", hs_low); else passed++;
        total++; if (vs_low !== 0) $display("FAIL vs_in_line0: got %0d expected 0", vs_low); else passed++;
        total++; if (lit !== 640) $display("FAIL active_width: got %0d expected 640", lit); else passed++;
        @(negedge CLOCK_50);
    endtask

    task automatic test_first_step();
        toggle_mode();
        total++; if (LEDG[3] !== 1'b1) $display("FAIL mode_toggle: got %b expected 1", LEDG[3]); else passed++;
        press_step();
        total++; if (LEDG[7:0] !== 8'b0000_1_100) $display("FAIL first_press: got %b expected 00001100", LEDG[7:0]); else passed++;
        press_step();
        total++; if (LEDG[7:0] !== 8'b0010_1_001) $display("FAIL head_rotate: got %b expected 00101001", LEDG[7:0]); else passed++;
    endtask

    task automatic test_trash_removal();
        press_step();
        total++; if ({LEDG[2:0], dut.pos_q.col} !== {3'b000, 5'd2}) $display("FAIL rotate_move: got st%b c%0d expected st000 c2", LEDG[2:0], dut.pos_q.col); else passed++;
        press_step();
        press_step();
        total++; if ({LEDG[7:4], LEDG[2:0], dut.pos_q.row, dut.pos_q.col} !== {4'b0010, 3'b000, 4'd1, 5'd4}) $display("FAIL follow_wall: got o%b st%b r%0d c%0d expected o0010 st000 r1 c4", LEDG[7:4], LEDG[2:0], dut.pos_q.row, dut.pos_q.col); else passed++;
        total++; if (dut.map_q[51:50] !== 2'b10) $display("FAIL trash_present: got %b expected 10", dut.map_q[51:50]); else passed++;
        press_step();
        total++; if ({LEDG[2:0], dut.pos_q.col} !== {3'b010, 5'd4}) $display("FAIL barrier_detect: got st%b c%0d expected st010 c4", LEDG[2:0], dut.pos_q.col); else passed++;
        press_step();
        total++; if ({LEDG[2:0], dut.map_q[51:50]} !== {3'b000, 2'b00}) $display("FAIL trash_cleared: got st%b cell%b expected st000 cell00", LEDG[2:0], dut.map_q[51:50]); else passed++;
        press_step();
        total++; if ({LEDG[2:0], dut.pos_q.col} !== {3'b000, 5'd5}) $display("FAIL move_into_cleared: got st%b c%0d expected st000 c5", LEDG[2:0], dut.pos_q.col); else passed++;
        toggle_mode();
        press_step();
        total++; if ({LEDG[3], LEDG[2:0], dut.pos_q.col} !== {1'b0, 3'b011, 5'd5}) $display("FAIL mode_off_standby: got m%b st%b c%0d expected m0 st011 c5", LEDG[3], LEDG[2:0], dut.pos_q.col); else passed++;
    endtask

    task automatic test_async_reset();
        tick(20);
        reset = 1'b1; #1;
        total++; if ({dut.pixel_x, dut.pixel_y} !== 20'h0) $display("FAIL async_counters: got x%0d y%0d expected x0 y0", dut.pixel_x, dut.pixel_y); else passed++;
        total++; if ({LEDG, dut.pos_q.row, dut.pos_q.col} !== {9'b0_0000_0_101, 4'd1, 5'd1}) $display("FAIL async_pose: got %b r%0d c%0d expected 000000101 r1 c1", LEDG, dut.pos_q.row, dut.pos_q.col); else passed++;
        total++; if (dut.map_q[51:50] !== 2'b10) $display("FAIL async_map: got %b expected 10", dut.map_q[51:50]); else passed++;
        tick(2); reset = 1'b0; tick(5);
    endtask

    task automatic test_manual();
        Pino4 = 1'b0; tick(4); press_step();
        total++; if ({LEDG[7:4], LEDG[2:0], dut.pos_q.row, dut.pos_q.col} !== {4'b0010, 3'b011, 4'd1, 5'd2}) $display("FAIL manual_right: got o%b st%b r%0d c%0d expected o0010 st011 r1 c2", LEDG[7:4], LEDG[2:0], dut.pos_q.row, dut.pos_q.col); else passed++;
        Pino4 = 1'b1; Pino2 = 1'b0; tick(4); press_step();
        total++; if ({LEDG[7:4], dut.pos_q.row, dut.pos_q.col} !== {4'b0001, 4'd2, 5'd2}) $display("FAIL manual_down: got o%b r%0d c%0d expected o0001 r2 c2", LEDG[7:4], dut.pos_q.row, dut.pos_q.col); else passed++;
        Pino1 = 1'b0; tick(4); press_step();
        total++; if ({LEDG[7:4], dut.pos_q.row, dut.pos_q.col} !== {4'b0000, 4'd1, 5'd2}) $display("FAIL manual_up_priority: got o%b r%0d c%0d expected o0000 r1 c2", LEDG[7:4], dut.pos_q.row, dut.pos_q.col); else passed++;
        Pino1 = 1'b1; Pino2 = 1'b1; Pino3 = 1'b0; tick(4); press_step();
        total++; if ({LEDG[7:4], dut.pos_q.col} !== {4'b0011, 5'd1}) $display("FAIL manual_left: got o%b c%0d expected o0011 c1", LEDG[7:4], dut.pos_q.col); else passed++;
        press_step();
        total++; if ({LEDG[7:4], dut.pos_q.row, dut.pos_q.col} !== {4'b0011, 4'd1, 5'd1}) $display("FAIL manual_wall_block: got o%b r%0d c%0d expected o0011 r1 c1", LEDG[7:4], dut.pos_q.row, dut.pos_q.col); else passed++;
        Pino3 = 1'b1; tick(4);
    endtask

    initial begin
        reset = 1'b0;
        KEY   = 4'hF;
        SW    = '0;
        Pino1 = 1'b1; Pino2 = 1'b1; Pino3 = 1'b1; Pino4 = 1'b1; Pino6 = 1'b1; Pino9 = 1'b1;
        tick(2);
        test_reset();
        test_sync_timing();
        test_first_step();
        test_trash_removal();
        test_async_reset();
        test_manual();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
